nshift_framer: RTL and testbench

- Downstream consumer of the N-bit serial-in/parallel-out shift register. Watches that register's parallel output and its shift enable.
- Hunts for a sync pattern, then slices every subsequent N shifted bits into a word.
- Words are handed to the next stage through a 2-entry valid/ready buffer.
- Provides lock status and a drop (overflow) indication.

---
 rtl/nshift_pkg.sv | 6 +
 rtl/nshift_word_fifo.sv | 43 ++++
 rtl/nshift_framer.sv | 79 +++++++
 tb/tb_nshift_framer.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/nshift_pkg.sv
// Shared types and constants for the shift-register word framer.
package nshift_pkg;
  typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;
  localparam logic [3:0] SYNC_DEFAULT = 4'b1011;
  localparam int FIFO_DEPTH = 2;
endpackage

// File: rtl/nshift_word_fifo.sv
// Two-entry word FIFO; head is presented combinationally from storage, 0 when empty.
module nshift_word_fifo
  import nshift_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [N-1:0] push_data,
  input  logic         pop,
  output logic [N-1:0] head,
  output logic         full,
  output logic         empty
);
  logic [N-1:0] mem [FIFO_DEPTH];
  logic         wr_ptr, rd_ptr;
  logic [1:0]   count;
  logic         do_push, do_pop;

  assign full    = (count == 2'(FIFO_DEPTH));
  assign empty   = (count == 2'd0);
  assign do_pop  = pop && !empty;
  // A pop on the same edge frees the slot the push lands in.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end
endmodule

// File: rtl/nshift_framer.sv
// Hunts for SYNC in the shift-register window, then slices every N shifted bits into a word.
module nshift_framer
  import nshift_pkg::*;
#(
  parameter int           N    = 4,
  parameter logic [N-1:0] SYNC = N'(SYNC_DEFAULT)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] sh_out,
  input  logic         sh_en,
  input  logic         sh_dir,
  input  logic         word_ready,
  output logic [N-1:0] word_out,
  output logic         word_valid,
  output logic         locked,
  output logic         overflow
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_t        state;
  logic [CW-1:0] bit_cnt;
  logic          upd, dir_q;
  logic          dir_chg, capture, pop, full, empty;

  // upd marks the cycle where sh_out already holds the freshly shifted bit.
  assign dir_chg    = (state == LOCK) && (sh_dir != dir_q);
  assign capture    = (state == LOCK) && upd && !dir_chg && (bit_cnt == CW'(N - 1));
  assign word_valid = !empty;
  assign pop        = word_valid && word_ready;

  nshift_word_fifo #(.N(N)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (capture),
    .push_data (sh_out),
    .pop       (pop),
    .head      (word_out),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HUNT;
      bit_cnt  <= '0;
      upd      <= 1'b0;
      dir_q    <= sh_dir;
      locked   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      upd      <= sh_en;
      dir_q    <= sh_dir;
      overflow <= capture && full && !pop;
      case (state)
        HUNT: begin
          if (upd && sh_out == SYNC) begin
            state   <= LOCK;
            bit_cnt <= '0;
            locked  <= 1'b1;
          end
        end
        LOCK: begin
          if (dir_chg) begin
            state   <= HUNT;
            bit_cnt <= '0;
            locked  <= 1'b0;
          end else if (upd) begin
            bit_cnt <= (bit_cnt == CW'(N - 1)) ? '0 : bit_cnt + 1'b1;
          end
        end
        default: begin
          state  <= HUNT;
          locked <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_nshift_framer.sv
// Directed scoreboard bench for nshift_framer: expected words queued at stimulus, popped by a monitor.
module tb_nshift_framer;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] sh_out;
  logic         sh_en;
  logic         sh_dir;
  logic         word_ready;
  logic [N-1:0] word_out;
  logic         word_valid;
  logic         locked;
  logic         overflow;

  int n_checks = 0;
  int n_pass   = 0;
  int ovf_cnt  = 0;
  logic [N-1:0] exp_q [$];

  always #5 clk = ~clk;

  nshift_framer #(.N(N), .SYNC(4'b1011)) dut (
    .clk        (clk),
    .rst        (rst),
    .sh_out     (sh_out),
    .sh_en      (sh_en),
    .sh_dir     (sh_dir),
    .word_ready (word_ready),
    .word_out   (word_out),
    .word_valid (word_valid),
    .locked     (locked),
    .overflow   (overflow)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Monitor: every accepted word must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst) begin
      if (overflow) ovf_cnt++;
      if (word_valid && word_ready) begin
        if (exp_q.size() == 0) chk("unexpected_word", {28'd0, word_out}, 32'hFFFF_FFFF);
        else chk("word", {28'd0, word_out}, {28'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // One shift: sh_en high for a cycle; sh_out shows v in the following (upd) cycle.
  task automatic shift(input logic [N-1:0] v);
    sh_en = 1'b1;
    @(posedge clk); #1;
    sh_out = v;
    sh_en  = 1'b0;
  endtask

  // Three filler shifts then the word-completing shift.
  task automatic word(input logic [N-1:0] v);
    repeat (3) shift(4'b0000);
    shift(v);
  endtask

  initial begin
    rst = 1'b1; sh_out = '0; sh_en = 1'b0; sh_dir = 1'b0; word_ready = 1'b1;
    tick(2);
    chk("rst_locked", locked, 0);
    chk("rst_valid", word_valid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_word_out", word_out, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("idle_locked", locked, 0);
      chk("idle_valid", word_valid, 0);
    end

    // Lock then one word.
    shift(4'b1011);
    tick();
    chk("lock_locked", locked, 1);
    exp_q.push_back(4'b0110);
    word(4'b0110);
    tick(3);
    chk("lock_drained", exp_q.size(), 0);
    chk("lock_still", locked, 1);

    // Backpressure: two held, third dropped.
    word_ready = 1'b0;
    exp_q.push_back(4'b0001); word(4'b0001);
    exp_q.push_back(4'b0010); word(4'b0010);
    word(4'b0011);
    tick(2);
    chk("bp_ovf", ovf_cnt, 1);
    chk("bp_valid", word_valid, 1);
    chk("bp_head", word_out, 4'b0001);
    word_ready = 1'b1;
    tick(3);
    chk("bp_drained", exp_q.size(), 0);
    chk("bp_empty", word_valid, 0);

    // Full buffer with a pop coinciding with the third capture.
    word_ready = 1'b0;
    exp_q.push_back(4'b0100); word(4'b0100);
    exp_q.push_back(4'b0101); word(4'b0101);
    exp_q.push_back(4'b0110);
    repeat (3) shift(4'b0000);
    shift(4'b0110);
    word_ready = 1'b1;
    tick(4);
    chk("fp_ovf", ovf_cnt, 1);
    chk("fp_drained", exp_q.size(), 0);

    // Direction change on the word-completing upd cycle suppresses the capture.
    repeat (3) shift(4'b0000);
    shift(4'b1110);
    sh_dir = ~sh_dir;
    tick();
    chk("dir_unlock", locked, 0);
    tick(2);
    chk("dir_no_word", word_valid, 0);
    shift(4'b1011);
    tick();
    chk("dir_relock", locked, 1);
    exp_q.push_back(4'b1001);
    word(4'b1001);
    tick(3);
    chk("dir_drained", exp_q.size(), 0);

    // Reset mid-word discards the buffered word.
    word_ready = 1'b0;
    word(4'b0111);
    shift(4'b0000); shift(4'b0000);
    tick();
    chk("mid_valid", word_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", word_valid, 0);
    chk("mid_rst_locked", locked, 0);
    word_ready = 1'b1;
    repeat (8) shift(4'b0000);
    tick(3);
    chk("mid_no_word", word_valid, 0);
    chk("mid_no_lock", locked, 0);

    chk("final_queue", exp_q.size(), 0);
    chk("final_ovf", ovf_cnt, 1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
